// File: rtl/decode_queue_if.sv
// decode_queue_if: bundles the fetch-side and dispatch-side signals of the decode queue.
// Latency: none; this is wiring only.
// Backpressure: fetch holds its group while if_ready is low; dispatch reports consumption on dp_num.
interface decode_queue_if #(
    parameter int WIDTH  = 2,
    parameter int PACK_W = 84   // width of the decoded pack presented per lane
);
    logic [WIDTH-1:0]                 if_valid;
    logic [WIDTH-1:0][31:0]           if_inst;
    logic [WIDTH-1:0][31:0]           if_pc;
    logic                             if_ready;
    logic [$clog2(WIDTH+1)-1:0]       dp_num;
    logic [WIDTH-1:0]                 out_valid;
    logic [WIDTH-1:0][PACK_W-1:0]     out_pack;

    modport master (output if_valid, if_inst, if_pc, dp_num,
                    input  if_ready, out_valid, out_pack);
    modport slave  (input  if_valid, if_inst, if_pc, dp_num,
                    output if_ready, out_valid, out_pack);
endinterface

// File: rtl/decode_queue.sv
// decode_queue: decodes up to WIDTH RV32IM lanes per cycle into an in-order queue for dispatch (option: DECODE_QUEUE_BYPASS_EN).
// Latency: enqueue to out_valid is one cycle; with DECODE_QUEUE_BYPASS_EN an empty queue forwards accepted lanes in the same cycle.
// Backpressure: if_ready comes from registered state only (RUN and room for a full group); dispatch pops dp_num head entries.
module decode_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    decode_queue_if.slave              dq,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halt,
    output logic                       illegal
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int NUM_W = $clog2(WIDTH+1);
    localparam logic [31:0] WFI    = 32'h1050_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // fu: 0 integer ALU, 1 multiply/divide, 2 load/store, 3 branch/jump/system
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        imm_valid;
        logic        rd_we;
        logic [1:0]  fu;
    } pack_t;

    typedef struct packed {
        pack_t pack;
        logic  halt;
        logic  illegal;
        logic  csr;
    } entry_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    // Register fields are raw instruction slices; immediates are sign-extended per format.
    function automatic entry_t decode(input logic [31:0] in, input logic [31:0] pc);
        entry_t      e;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] i_imm;
        logic        ok;
        f7    = in[31:25];
        f3    = in[14:12];
        i_imm = {{20{in[31]}}, in[31:20]};
        ok    = 1'b1;
        e     = '0;
        e.pack.pc  = pc;
        e.pack.rd  = in[11:7];
        e.pack.rs1 = in[19:15];
        e.pack.rs2 = in[24:20];
        case (in[6:0])
            7'b0110111, 7'b0010111: begin
                e.pack.imm = {in[31:12], 12'b0}; e.pack.imm_valid = 1'b1; e.pack.rd_we = 1'b1;
            end
            7'b1101111: begin
                e.pack.imm = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
                e.pack.imm_valid = 1'b1; e.pack.rd_we = 1'b1; e.pack.fu = 2'd3;
            end
            7'b1100111: begin
                e.pack.imm = i_imm; e.pack.imm_valid = 1'b1; e.pack.rd_we = 1'b1; e.pack.fu = 2'd3;
                ok = (f3 == 3'd0);
            end
            7'b1100011: begin
                e.pack.imm = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
                e.pack.imm_valid = 1'b1; e.pack.fu = 2'd3;
                ok = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'b0000011: begin
                e.pack.imm = i_imm; e.pack.imm_valid = 1'b1; e.pack.rd_we = 1'b1; e.pack.fu = 2'd2;
                ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            7'b0100011: begin
                e.pack.imm = {{20{in[31]}}, in[31:25], in[11:7]};
                e.pack.imm_valid = 1'b1; e.pack.fu = 2'd2;
                ok = (f3 < 3'd3);
            end
            7'b0010011: begin
                e.pack.imm = i_imm; e.pack.imm_valid = 1'b1; e.pack.rd_we = 1'b1;
                ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                     (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            end
            7'b0110011: begin
                e.pack.rd_we = 1'b1;
                e.pack.fu    = (f7 == 7'h01) ? 2'd1 : 2'd0;
                ok = (f7 == 7'h00) || (f7 == 7'h01) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'b0001111: ok = 1'b1;
            7'b1110011: begin
                e.pack.fu = 2'd3;
                if (f3 == 3'd0) begin
                    ok     = (in == ECALL) || (in == EBREAK) || (in == WFI);
                    e.halt = (in == WFI);
                end else begin
                    ok    = (f3 != 3'd4);
                    e.csr = 1'b1;
                    e.pack.imm = i_imm; e.pack.imm_valid = 1'b1; e.pack.rd_we = 1'b1;
                end
            end
            default: ok = 1'b0;
        endcase
        e.illegal    = !ok;
        e.pack.valid = ok;
        return e;
    endfunction

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halt_q, halt_d, illegal_q, illegal_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];

    entry_t             lane_e [WIDTH];
    entry_t             win [WIDTH];
    logic [WIDTH-1:0]   enq_lane, wr_lane, win_vld;
    logic [NUM_W-1:0]   n_enq;
    logic               if_ready_w, accept, stop, halt_c, ill_c;
    logic               unused_csr;  // csr flag rides along for downstream serialization

    assign if_ready_w  = (state_q == RUN) && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH));
    assign accept      = if_ready_w && !flush;
    assign dq.if_ready = if_ready_w;
    assign count       = count_q;
    assign halt        = halt_q;
    assign illegal     = illegal_q;

    // Decode all lanes; enqueue valid lanes up to and including the first halt/illegal lane
    always_comb begin
        enq_lane = '0;
        n_enq    = '0;
        stop     = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            lane_e[k] = decode(dq.if_inst[k], dq.if_pc[k]);
            if (accept && dq.if_valid[k] && !stop) begin
                enq_lane[k] = 1'b1;
                n_enq       = n_enq + 1'b1;
                stop        = lane_e[k].halt | lane_e[k].illegal;
            end
        end
    end

    // Present the head window (or forwarded lanes when empty) and collect flags of consumed entries
    always_comb begin
        win_vld    = '0;
        wr_lane    = enq_lane;
        halt_c     = 1'b0;
        ill_c      = 1'b0;
        unused_csr = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            win[i]     = mem_q[head_q + PTR_W'(i)];
            win_vld[i] = CNT_W'(i) < count_q;
        end
`ifdef DECODE_QUEUE_BYPASS_EN
        if (count_q == '0) begin
            win     = lane_e;
            win_vld = enq_lane;
            for (int i = 0; i < WIDTH; i++) begin
                if (NUM_W'(i) < dq.dp_num) wr_lane[i] = 1'b0;  // consumed on the fly, never stored
            end
        end
`endif
        for (int i = 0; i < WIDTH; i++) begin
            dq.out_pack[i] = win_vld[i] ? win[i].pack : '0;
            if (win_vld[i] && NUM_W'(i) < dq.dp_num) begin
                halt_c = halt_c | win[i].halt;
                ill_c  = ill_c  | win[i].illegal;
            end
            unused_csr = unused_csr | win[i].csr;
        end
        dq.out_valid = win_vld;
    end

    // Next state: flush beats enqueue and dequeue; consuming a flag entry is terminal until reset
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        halt_d    = halt_q;
        illegal_d = illegal_q;
        mem_d     = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (state_q == DRAIN) state_d = RUN;
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (wr_lane[k]) mem_d[tail_q + PTR_W'(k)] = lane_e[k];
            end
            head_d    = head_q + PTR_W'(dq.dp_num);
            tail_d    = tail_q + PTR_W'(n_enq);
            count_d   = count_q + CNT_W'(n_enq) - CNT_W'(dq.dp_num);
            halt_d    = halt_q | halt_c;
            illegal_d = illegal_q | ill_c;
            if (halt_c || ill_c) state_d = HALTED;
            else if (stop)       state_d = DRAIN;
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= RUN;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
        end
    end

    // Entry storage needs no reset: visibility is gated by count
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Dispatch may never consume more entries than are presented
    always_ff @(posedge clock) begin
        if (reset && !flush) assert ($countones(win_vld) >= int'(dq.dp_num));
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: randomized and directed stimulus against a queue-level reference model (honours DECODE_QUEUE_BYPASS_EN).
// Latency: outputs sampled 1 time unit after inputs change (before the next rising edge) and after rising edges.
// Backpressure: dispatch count is always chosen within the presented window.
module tb_decode_queue;
    localparam int DEPTH = 8;
    localparam int K_ADDI = 0, K_ADD = 1, K_SUB = 2, K_MUL = 3, K_LUI = 4, K_LW = 5,
                   K_SW = 6, K_BEQ = 7, K_CSR = 8, K_WFI = 9, K_ILL = 10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        imm_valid;
        logic        rd_we;
        logic [1:0]  fu;
    } pack_t;

    typedef struct {
        pack_t p;
        bit    halt;
        bit    ill;
    } ent_t;

    bit          clock = 1'b0;
    logic        reset, flush;
    logic [3:0]  count;
    logic        halt, illegal;
    int          n_cmp = 0, n_bad = 0;
    bit          byp;
    logic [31:0] pc_next = 32'h0;

    ent_t mq[$];
    bit   m_blocked = 1'b0, m_halted = 1'b0, m_halt = 1'b0, m_ill = 1'b0;

    always #5 clock = ~clock;

    decode_queue_if #(.WIDTH(2), .PACK_W(84)) dq ();

    decode_queue #(.DEPTH(DEPTH), .WIDTH(2)) dut (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .dq      (dq.slave),
        .count   (count),
        .halt    (halt),
        .illegal (illegal)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Encode an instruction of the given kind with random fields and state what it must decode to
    task automatic make(input int kind, input logic [31:0] pc, output logic [31:0] inst, output ent_t e);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [12:0] b13;
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        i12 = 12'($urandom); u20 = 20'($urandom); b13 = 13'($urandom) & 13'h1ffe;
        e.p = '0; e.p.valid = 1'b1; e.p.pc = pc; e.halt = 1'b0; e.ill = 1'b0;
        inst = 32'h0;
        case (kind)
            K_ADDI: begin inst = {i12, rs1, 3'b000, rd, 7'h13};
                e.p.imm = {{20{i12[11]}}, i12}; e.p.imm_valid = 1; e.p.rd_we = 1; end
            K_ADD:  begin inst = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; e.p.rd_we = 1; end
            K_SUB:  begin inst = {7'h20, rs2, rs1, 3'b000, rd, 7'h33}; e.p.rd_we = 1; end
            K_MUL:  begin inst = {7'h01, rs2, rs1, 3'b000, rd, 7'h33}; e.p.rd_we = 1; e.p.fu = 2'd1; end
            K_LUI:  begin inst = {u20, rd, 7'h37};
                e.p.imm = {u20, 12'b0}; e.p.imm_valid = 1; e.p.rd_we = 1; end
            K_LW:   begin inst = {i12, rs1, 3'b010, rd, 7'h03};
                e.p.imm = {{20{i12[11]}}, i12}; e.p.imm_valid = 1; e.p.rd_we = 1; e.p.fu = 2'd2; end
            K_SW:   begin inst = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
                e.p.imm = {{20{i12[11]}}, i12}; e.p.imm_valid = 1; e.p.fu = 2'd2; end
            K_BEQ:  begin inst = {b13[12], b13[10:5], rs2, rs1, 3'b000, b13[4:1], b13[11], 7'h63};
                e.p.imm = {{19{b13[12]}}, b13}; e.p.imm_valid = 1; e.p.fu = 2'd3; end
            K_CSR:  begin inst = {i12, rs1, 3'b001, rd, 7'h73};
                e.p.imm = {{20{i12[11]}}, i12}; e.p.imm_valid = 1; e.p.rd_we = 1; e.p.fu = 2'd3; end
            K_WFI:  begin inst = 32'h1050_0073; e.halt = 1; e.p.fu = 2'd3; end
            default: begin inst = 32'h0; e.ill = 1; e.p.valid = 0; end
        endcase
        e.p.rd  = inst[11:7];
        e.p.rs1 = inst[19:15];
        e.p.rs2 = inst[24:20];
    endtask

    // One cycle: drive at the falling edge, compare against the model, then advance the model
    task automatic step(input bit rst, input bit fl, input logic [1:0] vld,
                        input int k0, input int k1, input int dp);
        ent_t        lane [2];
        ent_t        enq[$];
        ent_t        vis[$];
        logic [31:0] inst;
        logic [1:0]  mask;
        bit          rdy, acc, stop;
        int          ndp;
        ent_t        e;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            make((k == 0) ? k0 : k1, pc_next + 32'(4 * k), inst, lane[k]);
            dq.if_inst[k] = inst;
            dq.if_pc[k]   = pc_next + 32'(4 * k);
        end
        pc_next     = pc_next + 32'd8;
        reset       = !rst;
        flush       = fl;
        dq.if_valid = vld;
        rdy  = !m_halted && !m_blocked && (DEPTH - mq.size() >= 2);
        acc  = rdy && !fl;
        stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (acc && vld[k] && !stop) begin
                enq.push_back(lane[k]);
                stop = lane[k].halt || lane[k].ill;
            end
        end
        if (byp && mq.size() == 0 && acc) vis = enq;
        else for (int i = 0; i < 2 && i < mq.size(); i++) vis.push_back(mq[i]);
        if (dp < 0) ndp = $urandom_range(0, vis.size());
        else        ndp = (dp > vis.size()) ? vis.size() : dp;
        dq.dp_num = 2'(ndp);
        #1;
        mask = '0;
        for (int i = 0; i < vis.size(); i++) mask[i] = 1'b1;
        check("if_ready", dq.if_ready, rdy);
        check("count", count, mq.size());
        check("halt", halt, m_halt);
        check("illegal", illegal, m_ill);
        check("out_valid", dq.out_valid, mask);
        for (int i = 0; i < 2; i++)
            check("out_pack", dq.out_pack[i], (i < vis.size()) ? vis[i].p : pack_t'('0));
        if (rst) begin
            mq.delete();
            m_blocked = 0; m_halted = 0; m_halt = 0; m_ill = 0;
        end else if (fl) begin
            mq.delete();
            m_blocked = 0;
        end else begin
            foreach (enq[i]) begin
                mq.push_back(enq[i]);
                if (enq[i].halt || enq[i].ill) m_blocked = 1;
            end
            for (int n = 0; n < ndp; n++) begin
                e = mq.pop_front();
                if (e.halt) begin m_halt = 1; m_halted = 1; end
                if (e.ill)  begin m_ill  = 1; m_halted = 1; end
            end
        end
    endtask

    task automatic settle;
        @(posedge clock);
        #1;
    endtask

    function automatic int rkind();
        int n;
        n = $urandom_range(0, 31);
        if (n == 0) return K_WFI;
        if (n == 1) return K_ILL;
        return n % 9;
    endfunction

    initial begin
        pack_t p0, p1;
`ifdef DECODE_QUEUE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        reset = 1'b0; flush = 1'b0;
        dq.if_valid = '0; dq.if_inst = '0; dq.if_pc = '0; dq.dp_num = '0;
        repeat (2) @(posedge clock);

        // reset state
        step(1, 0, 2'b00, K_ADD, K_ADD, 0);
        settle;
        check("rst_count", count, 4'd0);
        check("rst_out_valid", dq.out_valid, 2'b00);
        check("rst_if_ready", dq.if_ready, 1'b1);

        // two ADDI lanes at pc 0x0 / 0x4
        pc_next = 32'h0;
        step(0, 0, 2'b11, K_ADDI, K_ADDI, 0);
        settle;
        p0 = dq.out_pack[0];
        p1 = dq.out_pack[1];
        check("addi_count", count, 4'd2);
        check("addi_out_valid", dq.out_valid, 2'b11);
        check("addi_pc0", p0.pc, 32'h0);
        check("addi_pc1", p1.pc, 32'h4);
        check("addi_imm_valid", p0.imm_valid, 1'b1);

        // fill to DEPTH, try to overfill, then drain with wrap
        repeat (3) step(0, 0, 2'b11, K_ADD, K_MUL, 0);
        settle;
        check("full_count", count, 4'd8);
        check("full_if_ready", dq.if_ready, 1'b0);
        step(0, 0, 2'b11, K_SUB, K_SUB, 0);
        repeat (4) step(0, 0, 2'b00, K_ADD, K_ADD, 2);
        settle;
        check("drained_count", count, 4'd0);

        // WFI group: only WFI enters, queue drains to HALTED, halt is sticky through flush
        step(0, 0, 2'b11, K_WFI, K_ADD, 0);
        settle;
        check("wfi_count", count, 4'd1);
        check("wfi_if_ready", dq.if_ready, 1'b0);
        step(0, 0, 2'b00, K_ADD, K_ADD, 1);
        settle;
        check("wfi_halt", halt, 1'b1);
        step(0, 1, 2'b00, K_ADD, K_ADD, 0);
        settle;
        check("halt_sticky", halt, 1'b1);
        check("halted_if_ready", dq.if_ready, 1'b0);
        step(1, 0, 2'b00, K_ADD, K_ADD, 0);

        // illegal entry: flush returns to RUN; consumed it sets illegal
        step(0, 0, 2'b01, K_ILL, K_ADD, 0);
        settle;
        p0 = dq.out_pack[0];
        check("ill_out_valid", dq.out_valid, 2'b01);
        check("ill_pack_valid", p0.valid, 1'b0);
        step(0, 1, 2'b00, K_ADD, K_ADD, 0);
        settle;
        check("ill_flush_if_ready", dq.if_ready, 1'b1);
        step(0, 0, 2'b01, K_ILL, K_ADD, 0);
        step(0, 0, 2'b00, K_ADD, K_ADD, 1);
        settle;
        check("ill_sticky", illegal, 1'b1);
        check("ill_halted_if_ready", dq.if_ready, 1'b0);
        step(1, 0, 2'b00, K_ADD, K_ADD, 0);

        // flush beats same-cycle enqueue and dequeue
        step(0, 0, 2'b11, K_LW, K_SW, 0);
        step(0, 0, 2'b11, K_BEQ, K_LUI, 0);
        step(0, 0, 2'b01, K_CSR, K_ADD, 0);
        step(0, 1, 2'b11, K_ADD, K_ADD, 2);
        settle;
        check("flush_count", count, 4'd0);
        check("flush_out_valid", dq.out_valid, 2'b00);
        check("flush_if_ready", dq.if_ready, 1'b1);

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            bit         r, f;
            logic [1:0] v;
            r = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0) || (m_blocked && $urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0:       v = 2'b00;
                1:       v = 2'b01;
                default: v = 2'b11;
            endcase
            step(r, f, v, rkind(), rkind(), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
